// File: rtl/ray_pkg.sv
// rtl/ray_pkg.sv - shared widths and constants for the ray sample-point pipeline
package ray_pkg;
    localparam int ORI_W_D     = 11;
    localparam int DIR_W_D     = 10;
    localparam int FRAC_D      = 8;
    localparam int T_W_D       = 19;
    localparam int T_VALID_W_D = 10;
    localparam int POS_W_D     = 12;
    localparam int TAG_W_D     = 8;

    // Coordinate reported for a ray whose distance is out of range (-1 at any width).
    localparam logic [63:0] MISS_COORD = '1;
endpackage

// File: rtl/ray_point_pipe_if.sv
// rtl/ray_point_pipe_if.sv - request/result handshake bundle of ray_point_pipe
interface ray_point_pipe_if import ray_pkg::*; #(
    parameter int ORI_W     = ORI_W_D,
    parameter int DIR_W     = DIR_W_D,
    parameter int T_W       = T_W_D,
    parameter int T_VALID_W = T_VALID_W_D,
    parameter int POS_W     = POS_W_D,
    parameter int TAG_W     = TAG_W_D
);
    logic                        in_valid;
    logic                        in_ready;
    logic [T_W-1:0]              in_t;
    logic signed [ORI_W-1:0]     in_ori_x, in_ori_y, in_ori_z;
    logic signed [DIR_W-1:0]     in_dir_x, in_dir_y, in_dir_z;
    logic [TAG_W-1:0]            in_tag;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [POS_W-1:0]     out_x, out_y, out_z;
    logic [T_VALID_W-1:0]        out_t;
    logic                        out_miss;
    logic                        out_sat;
    logic [TAG_W-1:0]            out_tag;

    modport master (
        output in_valid, in_t, in_ori_x, in_ori_y, in_ori_z,
               in_dir_x, in_dir_y, in_dir_z, in_tag, out_ready,
        input  in_ready, out_valid, out_x, out_y, out_z, out_t,
               out_miss, out_sat, out_tag
    );

    modport slave (
        input  in_valid, in_t, in_ori_x, in_ori_y, in_ori_z,
               in_dir_x, in_dir_y, in_dir_z, in_tag, out_ready,
        output in_ready, out_valid, out_x, out_y, out_z, out_t,
               out_miss, out_sat, out_tag
    );
endinterface

// File: rtl/ray_axis_mac.sv
// rtl/ray_axis_mac.sv - one axis: registered dir*t product, then offset, round and saturate
module ray_axis_mac import ray_pkg::*; #(
    parameter int ORI_W     = ORI_W_D,
    parameter int DIR_W     = DIR_W_D,
    parameter int FRAC      = FRAC_D,
    parameter int T_VALID_W = T_VALID_W_D,
    parameter int POS_W     = POS_W_D,
    parameter int ROUND     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic signed [ORI_W-1:0] ori,
    input  logic signed [DIR_W-1:0] dir,
    input  logic [T_VALID_W-1:0]    t_low,
    output logic signed [POS_W-1:0] res,
    output logic                    sat
);
    localparam int PROD_W = DIR_W + T_VALID_W + 1;
    localparam int OFS_W  = ORI_W + FRAC;
    localparam int SUM_W  = ((PROD_W > OFS_W) ? PROD_W : OFS_W) + 2;

    localparam logic signed [SUM_W-1:0] RND     = (ROUND != 0) ? SUM_W'(1 << (FRAC - 1)) : '0;
    localparam logic signed [SUM_W-1:0] POS_MAX = {{(SUM_W-POS_W+1){1'b0}}, {(POS_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] POS_MIN = {{(SUM_W-POS_W+1){1'b1}}, {(POS_W-1){1'b0}}};

    logic signed [PROD_W-1:0] prod_q;
    logic signed [ORI_W-1:0]  ori_q;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            ori_q  <= '0;
        end else if (load) begin
            prod_q <= PROD_W'(dir) * PROD_W'($signed({1'b0, t_low}));
            ori_q  <= ori;
        end
    end

    // Sum is wide enough that neither the offset nor the rounding bias can wrap.
    always_comb begin
        sum     = (SUM_W'(ori_q) <<< FRAC) + SUM_W'(prod_q) + RND;
        shifted = sum >>> FRAC;
        sat     = 1'b0;
        res     = shifted[POS_W-1:0];
        if (shifted > POS_MAX) begin
            res = POS_MAX[POS_W-1:0];
            sat = 1'b1;
        end else if (shifted < POS_MIN) begin
            res = POS_MIN[POS_W-1:0];
            sat = 1'b1;
        end
    end
endmodule

// File: rtl/ray_point_pipe.sv
// rtl/ray_point_pipe.sv - two-stage P = ORI + DIR*t evaluator with valid/ready flow control
module ray_point_pipe import ray_pkg::*; #(
    parameter int ORI_W     = ORI_W_D,
    parameter int DIR_W     = DIR_W_D,
    parameter int FRAC      = FRAC_D,
    parameter int T_W       = T_W_D,
    parameter int T_VALID_W = T_VALID_W_D,
    parameter int POS_W     = POS_W_D,
    parameter int TAG_W     = TAG_W_D,
    parameter int ROUND     = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    ray_point_pipe_if.slave io
);
    generate
        if (T_VALID_W > T_W) begin : g_bad_t
            $error("ray_point_pipe: T_VALID_W must not exceed T_W");
        end
        if (ROUND != 0 && FRAC < 1) begin : g_bad_round
            $error("ray_point_pipe: rounding needs FRAC >= 1");
        end
    endgenerate

    logic                 s1_valid;
    logic                 s1_miss;
    logic [T_VALID_W-1:0] s1_t;
    logic [TAG_W-1:0]     s1_tag;
    logic                 s1_load;
    logic                 s2_advance;
    logic signed [POS_W-1:0] res_x, res_y, res_z;
    logic                 sat_x, sat_y, sat_z;

    assign s2_advance  = !io.out_valid || io.out_ready;
    assign io.in_ready = !s1_valid || s2_advance;
    assign s1_load     = io.in_valid && io.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_miss  <= 1'b0;
            s1_t     <= '0;
            s1_tag   <= '0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_miss  <= |io.in_t[T_W-1:T_VALID_W];
            s1_t     <= io.in_t[T_VALID_W-1:0];
            s1_tag   <= io.in_tag;
        end else if (s2_advance) begin
            s1_valid <= 1'b0;
        end
    end

    ray_axis_mac #(.ORI_W(ORI_W), .DIR_W(DIR_W), .FRAC(FRAC), .T_VALID_W(T_VALID_W),
                   .POS_W(POS_W), .ROUND(ROUND)) u_mac_x (
        .clk(clk), .rst_n(rst_n), .load(s1_load), .ori(io.in_ori_x), .dir(io.in_dir_x),
        .t_low(io.in_t[T_VALID_W-1:0]), .res(res_x), .sat(sat_x));
    ray_axis_mac #(.ORI_W(ORI_W), .DIR_W(DIR_W), .FRAC(FRAC), .T_VALID_W(T_VALID_W),
                   .POS_W(POS_W), .ROUND(ROUND)) u_mac_y (
        .clk(clk), .rst_n(rst_n), .load(s1_load), .ori(io.in_ori_y), .dir(io.in_dir_y),
        .t_low(io.in_t[T_VALID_W-1:0]), .res(res_y), .sat(sat_y));
    ray_axis_mac #(.ORI_W(ORI_W), .DIR_W(DIR_W), .FRAC(FRAC), .T_VALID_W(T_VALID_W),
                   .POS_W(POS_W), .ROUND(ROUND)) u_mac_z (
        .clk(clk), .rst_n(rst_n), .load(s1_load), .ori(io.in_ori_z), .dir(io.in_dir_z),
        .t_low(io.in_t[T_VALID_W-1:0]), .res(res_z), .sat(sat_z));

    // A miss overrides the arithmetic entirely: coordinates and distance go all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io.out_valid <= 1'b0;
            io.out_x     <= '0;
            io.out_y     <= '0;
            io.out_z     <= '0;
            io.out_t     <= '0;
            io.out_miss  <= 1'b0;
            io.out_sat   <= 1'b0;
            io.out_tag   <= '0;
        end else if (s2_advance) begin
            io.out_valid <= s1_valid;
            if (s1_valid) begin
                io.out_x    <= s1_miss ? MISS_COORD[POS_W-1:0] : res_x;
                io.out_y    <= s1_miss ? MISS_COORD[POS_W-1:0] : res_y;
                io.out_z    <= s1_miss ? MISS_COORD[POS_W-1:0] : res_z;
                io.out_t    <= s1_miss ? '1 : s1_t;
                io.out_miss <= s1_miss;
                io.out_sat  <= !s1_miss && (sat_x || sat_y || sat_z);
                io.out_tag  <= s1_tag;
            end
        end
    end
endmodule

// File: tb/tb_ray_point_pipe.sv
// tb/tb_ray_point_pipe.sv - scoreboard bench running floor and round-half-up instances in lockstep
module tb_ray_point_pipe;
    typedef struct packed {
        logic [11:0] x, y, z;
        logic [9:0]  t;
        logic        miss, sat;
        logic [7:0]  tag;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ray_point_pipe_if if0 ();
    ray_point_pipe_if if1 ();

    assign if1.in_valid  = if0.in_valid;
    assign if1.in_t      = if0.in_t;
    assign if1.in_ori_x  = if0.in_ori_x;
    assign if1.in_ori_y  = if0.in_ori_y;
    assign if1.in_ori_z  = if0.in_ori_z;
    assign if1.in_dir_x  = if0.in_dir_x;
    assign if1.in_dir_y  = if0.in_dir_y;
    assign if1.in_dir_z  = if0.in_dir_z;
    assign if1.in_tag    = if0.in_tag;
    assign if1.out_ready = if0.out_ready;

    ray_point_pipe #(.ROUND(0)) dut0 (.clk(clk), .rst_n(rst_n), .io(if0.slave));
    ray_point_pipe #(.ROUND(1)) dut1 (.clk(clk), .rst_n(rst_n), .io(if1.slave));

    int   tests = 0;
    int   fails = 0;
    res_t q0[$];
    res_t q1[$];
    res_t hold0, hold1, act0, act1;
    bit   held0 = 1'b0;
    bit   held1 = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    // Returns {sat, coord} for one axis using plain wide integer arithmetic.
    function automatic logic [12:0] axis(input longint o, input longint d, input longint tt, input int rnd);
        longint v;
        v = (o * 256 + d * tt + ((rnd != 0) ? 128 : 0)) >>> 8;
        if (v > 2047)  return {1'b1, 12'h7FF};
        if (v < -2048) return {1'b1, 12'h800};
        return {1'b0, v[11:0]};
    endfunction

    function automatic res_t model(input int rnd);
        res_t r;
        logic [12:0] ax, ay, az;
        logic [18:0] t;
        t = if0.in_t;
        r.tag = if0.in_tag;
        if (t[18:10] != 9'd0) begin
            r.x = '1; r.y = '1; r.z = '1; r.t = '1; r.miss = 1'b1; r.sat = 1'b0;
            return r;
        end
        ax = axis(longint'(if0.in_ori_x), longint'(if0.in_dir_x), longint'(t[9:0]), rnd);
        ay = axis(longint'(if0.in_ori_y), longint'(if0.in_dir_y), longint'(t[9:0]), rnd);
        az = axis(longint'(if0.in_ori_z), longint'(if0.in_dir_z), longint'(t[9:0]), rnd);
        r.x = ax[11:0]; r.y = ay[11:0]; r.z = az[11:0];
        r.t = t[9:0]; r.miss = 1'b0;
        r.sat = ax[12] | ay[12] | az[12];
        return r;
    endfunction

    // Handshakes are sampled mid-cycle; each transfer completes at the following rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            held0 = 1'b0;
            held1 = 1'b0;
        end else begin
            if (if0.in_valid && if0.in_ready) q0.push_back(model(0));
            if (if1.in_valid && if1.in_ready) q1.push_back(model(1));
            act0 = {if0.out_x, if0.out_y, if0.out_z, if0.out_t, if0.out_miss, if0.out_sat, if0.out_tag};
            act1 = {if1.out_x, if1.out_y, if1.out_z, if1.out_t, if1.out_miss, if1.out_sat, if1.out_tag};
            if (held0) chk("dut0_stall_hold", {if0.out_valid, act0}, {1'b1, hold0});
            if (held1) chk("dut1_stall_hold", {if1.out_valid, act1}, {1'b1, hold1});
            if (if0.out_valid && if0.out_ready) begin
                chk("dut0_expected_pending", q0.size() != 0, 1);
                if (q0.size() != 0) chk("dut0_result", act0, q0.pop_front());
            end
            if (if1.out_valid && if1.out_ready) begin
                chk("dut1_expected_pending", q1.size() != 0, 1);
                if (q1.size() != 0) chk("dut1_result", act1, q1.pop_front());
            end
            held0 = if0.out_valid && !if0.out_ready;
            held1 = if1.out_valid && !if1.out_ready;
            hold0 = act0;
            hold1 = act1;
        end
    end

    task automatic send(input logic signed [10:0] ox, input logic signed [10:0] oy, input logic signed [10:0] oz,
                        input logic signed [9:0] dx, input logic signed [9:0] dy, input logic signed [9:0] dz,
                        input logic [18:0] t, input logic [7:0] tag);
        bit acc;
        acc = 1'b0;
        if0.in_ori_x = ox; if0.in_ori_y = oy; if0.in_ori_z = oz;
        if0.in_dir_x = dx; if0.in_dir_y = dy; if0.in_dir_z = dz;
        if0.in_t = t; if0.in_tag = tag; if0.in_valid = 1'b1;
        for (int i = 0; i < 64 && !acc; i++) begin
            @(negedge clk);
            acc = if0.in_ready;
            @(posedge clk);
            #1;
        end
        chk("send_accepted", acc, 1);
    endtask

    task automatic drain();
        if0.in_valid = 1'b0;
        if0.out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && !if0.out_valid && !if1.out_valid) break;
        end
        chk("drain_q0_empty", q0.size(), 0);
        chk("drain_q1_empty", q1.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        if0.in_valid = 1'b0; if0.in_t = '0; if0.in_tag = '0;
        if0.in_ori_x = '0; if0.in_ori_y = '0; if0.in_ori_z = '0;
        if0.in_dir_x = '0; if0.in_dir_y = '0; if0.in_dir_z = '0;
        if0.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid0", if0.out_valid, 0);
        chk("rst_out_valid1", if1.out_valid, 0);
        chk("rst_outputs0", {if0.out_x, if0.out_y, if0.out_z, if0.out_t, if0.out_miss, if0.out_sat, if0.out_tag}, 0);
        chk("rst_outputs1", {if1.out_x, if1.out_y, if1.out_z, if1.out_t, if1.out_miss, if1.out_sat, if1.out_tag}, 0);
        chk("rst_in_ready", if0.in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(11'sd10, -11'sd5, 11'sd0, 10'sd256, -10'sd128, 10'sd0, 19'd4, 8'h3C);
        drain();
        chk("t1_is_14_-7_0", {q0.size(), 1'b0}, 0);

        send(11'sd100, 11'sd3, -11'sd7, 10'sd50, 10'sd1, -10'sd9, 19'd1024, 8'h11);
        send(11'sd1, 11'sd2, 11'sd3, 10'sd4, 10'sd5, 10'sd6, 19'h7FFFF, 8'h12);
        send(11'sd1, 11'sd2, 11'sd3, 10'sd4, 10'sd5, 10'sd6, 19'd1023, 8'h13);
        drain();

        send(11'sd1023, 11'sd0, 11'sd0, 10'sd511, 10'sd0, 10'sd0, 19'd1023, 8'h21);
        send(-11'sd1024, 11'sd0, 11'sd0, -10'sd512, 10'sd0, 10'sd0, 19'd1023, 8'h22);
        drain();

        send(11'sd0, 11'sd0, 11'sd0, 10'sd128, 10'sd0, 10'sd0, 19'd1, 8'h31);
        send(11'sd0, 11'sd0, 11'sd0, -10'sd128, 10'sd0, 10'sd0, 19'd1, 8'h32);
        drain();

        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    logic [18:0] tt;
                    tt = ($urandom_range(0, 5) == 0) ? 19'($urandom_range(1024, 524287))
                                                     : 19'($urandom_range(0, 1023));
                    send(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)),
                         10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                         tt, 8'(8'h40 + k));
                end
                if0.in_valid = 1'b0;
            end
            begin
                for (int j = 0; j < 30; j++) begin
                    @(posedge clk);
                    #1;
                    if0.out_ready = ~if0.out_ready;
                end
            end
        join
        drain();

        if0.out_ready = 1'b0;
        send(11'sd5, 11'sd6, 11'sd7, 10'sd1, 10'sd2, 10'sd3, 19'd9, 8'h51);
        send(11'sd8, 11'sd9, 11'sd10, 10'sd1, 10'sd2, 10'sd3, 19'd9, 8'h52);
        if0.in_valid = 1'b0;
        @(negedge clk);
        chk("inflight_out_valid", if0.out_valid, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid0", if0.out_valid, 0);
        chk("midrst_out_valid1", if1.out_valid, 0);
        chk("midrst_out_x", if0.out_x, 0);
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        if0.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", {if0.out_valid, if1.out_valid}, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
